rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters sharing one ROM (2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, ROM address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 24, ROM data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester read request; bit i held high until gnt[i] seen.
REQ-007 lock  input  NUM_REQ  per-requester burst lock; sampled only with req.
REQ-008 req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 gnt  output  NUM_REQ  one-hot combinational grant, this cycle's ROM access.
REQ-010 rom_addr  output  ADDR_WIDTH  address to the synchronous ROM (1-cycle registered read).
REQ-011 rom_rdata  input  DATA_WIDTH  ROM registered read data.
REQ-012 rd_valid  output  NUM_REQ  one-hot, marks owner of rd_data this cycle.
REQ-013 rd_data  output  DATA_WIDTH  equals rom_rdata, passthrough.

Function
REQ-014 gnt SHALL have at most one bit set; gnt SHALL be zero when req is zero.
REQ-015 Arbitration SHALL be round-robin: search starts at index ptr, wraps NUM_REQ-1 -> 0; first set req bit wins.
REQ-016 On a grant to i in UNLOCKED state, ptr SHALL update to (i+1) mod NUM_REQ at next edge; no grant -> ptr unchanged.
REQ-017 rom_addr SHALL be req_addr slice of granted requester; with no grant, rom_addr SHALL hold its last granted value (registered copy, reset 0).
REQ-018 rd_valid SHALL be gnt delayed by exactly one cycle (registered); read latency req-grant -> data = 1 cycle.
REQ-019 One grant per cycle SHALL be sustainable; back-to-back grants to same or different requesters allowed.
REQ-020 State machine: UNLOCKED, LOCKED(owner). UNLOCKED -> LOCKED when granted requester i has lock[i]=1; owner := i.
REQ-021 In LOCKED, gnt SHALL equal req[owner] on bit owner only; other requesters SHALL receive no grant; ptr frozen.
REQ-022 LOCKED -> UNLOCKED when owner presents req=1, lock=0 (final access granted, ptr := owner+1) or when req[owner]=0 (no grant to owner; arbitration resumes same cycle from ptr).
REQ-023 lock without req SHALL be ignored.
REQ-024 Address change on a requester's req_addr while not granted SHALL not affect any other requester's data.

Reset
REQ-025 During rst: ptr=0, state UNLOCKED, rd_valid=0, rom_addr register=0; gnt SHALL be forced 0 while rst high.
REQ-026 Assertion of rst mid-burst SHALL discard the pending rd_valid immediately (async) and release lock; first cycle after deassert arbitrates from index 0.

Verification
REQ-027 Single: req=0001, addr0=0x12 -> gnt=0001, rom_addr=0x12; next cycle rd_valid=0001, rd_data=ROM[0x12].
REQ-028 Fairness: req=1111 held, each requester drops req after its grant and re-raises next cycle -> grants 0001,0010,0100,1000,0001 in consecutive cycles.
REQ-029 Wrap: ptr=3, req=0011 -> gnt=0001, ptr becomes 1 next cycle.
REQ-030 Lock: req=0110, lock=0010, requester 1 bursts addr 0x40..0x43 -> gnt=0010 four cycles, requester 2 starved; lock drops on 0x43 -> next grant 0100; rd_valid trails each grant by one cycle.
REQ-031 Reset mid-op: rst asserted in cycle after grant to 2 -> rd_valid=0 immediately, after deassert req=1111 -> gnt=0001.
REQ-032 Idle: req=0 for 10 cycles -> gnt=0, rd_valid=0, rom_addr stable at last value.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter that shares one synchronous ROM between
// NUM_REQ requesters. A requester may lock the ROM for a burst. The grant
// is combinational. Read data comes back one cycle later, and rd_valid
// marks which requester owns it.
module rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_rdata,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [PTR_W-1:0]        owner_reg, owner_next;
  logic [PTR_W-1:0]        win_idx;
  logic [PTR_W-1:0]        cand_idx;
  logic                    grant_any;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [NUM_REQ-1:0]      rd_valid_reg;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

  // Index arithmetic modulo NUM_REQ. This stays correct when NUM_REQ is
  // not a power of two.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return PTR_W'(sum);
  endfunction

  // Split the flattened address bus into one slice per requester.
  // Decode the winner index into a one-hot grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign gnt[gi]      = grant_any && (win_idx == PTR_W'(gi));
    end
  endgenerate

  // Choose the winner and compute the next lock state and pointer.
  // A locked owner that keeps req high always wins. Otherwise, a
  // round-robin search runs from ptr.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    win_idx    = owner_reg;
    cand_idx   = ptr_reg;
    grant_any  = 1'b0;
    if (!rst) begin
      if (state_reg == ST_LOCKED && req[owner_reg]) begin
        // Burst continues. ptr stays frozen until the final (unlocked) beat.
        grant_any = 1'b1;
        win_idx   = owner_reg;
        if (!lock[owner_reg]) begin
          state_next = ST_UNLOCKED;
          ptr_next   = wrap_add(owner_reg, 1);
        end
      end else begin
        // Unlocked, or the owner let go. Arbitrate in this same cycle.
        state_next = ST_UNLOCKED;
        for (int k = 0; k < NUM_REQ; k++) begin
          cand_idx = wrap_add(ptr_reg, k);
          if (!grant_any && req[cand_idx]) begin
            grant_any = 1'b1;
            win_idx   = cand_idx;
          end
        end
        if (grant_any) begin
          ptr_next = wrap_add(win_idx, 1);
          if (lock[win_idx]) begin
            state_next = ST_LOCKED;
            owner_next = win_idx;
          end
        end
      end
    end
  end

  // Arbitration state: lock state, lock owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_UNLOCKED;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // Keep the last granted address. Delay the grant so it lines up with ROM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      rd_valid_reg <= '0;
    end else begin
      rd_valid_reg <= gnt;
      if (grant_any) begin
        addr_reg <= addr_arr[win_idx];
      end
    end
  end

  assign rom_addr = grant_any ? addr_arr[win_idx] : addr_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rom_rdata;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed stimulus for rom_arbiter with a behavioural
// model. A per-cycle comparer checks the DUT against the model, and literal
// expectations pin the directed scenarios.
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 24;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_rdata;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;

  logic [AW-1:0]   addr_q [N];

  int total = 0;
  int bad   = 0;

  rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM content is a fixed function of the address.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A};
  endfunction

  always @(posedge clk) rom_rdata <= rom_f(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: round-robin pointer, lock owner, last address and
  // the previous cycle's grant. It is evaluated on every falling edge.
  int            m_ptr = 0;
  bit            m_locked = 0;
  int            m_owner = 0;
  logic [AW-1:0] m_last = '0;
  logic [N-1:0]  m_prev_gnt = '0;
  logic [AW-1:0] m_prev_addr = '0;

  always @(negedge clk) begin
    int            w;
    logic [N-1:0]  exp_gnt;
    logic [AW-1:0] exp_addr;
    if (rst) begin
      chk("cyc_rst_gnt", 32'(gnt), 32'h0);
      chk("cyc_rst_rdv", 32'(rd_valid), 32'h0);
      chk("cyc_rst_addr", 32'(rom_addr), 32'h0);
      m_ptr = 0; m_locked = 0; m_owner = 0; m_last = '0;
      m_prev_gnt = '0; m_prev_addr = '0;
    end else begin
      chk("cyc_rdv", 32'(rd_valid), 32'(m_prev_gnt));
      chk("cyc_passthru", 32'(rd_data), 32'(rom_rdata));
      if (m_prev_gnt != '0) chk("cyc_rdata", 32'(rd_data), 32'(rom_f(m_prev_addr)));
      w = -1;
      if (m_locked && req[m_owner]) begin
        w = m_owner;
      end else begin
        m_locked = 0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (w < 0 && req[idx]) w = idx;
        end
      end
      exp_gnt  = (w < 0) ? '0 : N'(1) << w;
      exp_addr = (w < 0) ? m_last : req_addr[w*AW +: AW];
      chk("cyc_gnt", 32'(gnt), 32'(exp_gnt));
      chk("cyc_addr", 32'(rom_addr), 32'(exp_addr));
      if (w >= 0) begin
        if (m_locked) begin
          if (!lock[w]) begin
            m_locked = 0;
            m_ptr = (w + 1) % N;
          end
        end else begin
          m_ptr = (w + 1) % N;
          if (lock[w]) begin
            m_locked = 1;
            m_owner = w;
          end
        end
        m_last = exp_addr;
      end
      m_prev_gnt  = exp_gnt;
      m_prev_addr = exp_addr;
    end
  end

  // Drive one cycle of inputs just after the rising edge, then settle at the falling edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l);
    @(posedge clk);
    #1;
    req = r;
    lock = l;
    req_addr = {addr_q[3], addr_q[2], addr_q[1], addr_q[0]};
    @(negedge clk);
    $display("step req=%b lock=%b gnt=%b rd_valid=%b rom_addr=%h rd_data=%h",
             req, lock, gnt, rd_valid, rom_addr, rd_data);
  endtask

  logic [N-1:0] fair_req [5];
  logic [N-1:0] fair_gnt [5];

  initial begin
    rst = 1'b1;
    req = '0;
    lock = '0;
    for (int i = 0; i < N; i++) addr_q[i] = '0;
    req_addr = '0;
    fair_req[0] = 4'b1111; fair_gnt[0] = 4'b0001;
    fair_req[1] = 4'b1110; fair_gnt[1] = 4'b0010;
    fair_req[2] = 4'b1101; fair_gnt[2] = 4'b0100;
    fair_req[3] = 4'b1011; fair_gnt[3] = 4'b1000;
    fair_req[4] = 4'b0111; fair_gnt[4] = 4'b0001;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rdv", 32'(rd_valid), 32'h0);
    chk("reset_addr", 32'(rom_addr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read
    addr_q[0] = 8'h12;
    step(4'b0001, 4'b0000);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_addr", 32'(rom_addr), 32'h12);
    step(4'b0000, 4'b0000);
    chk("single_rdv", 32'(rd_valid), 32'h1);
    chk("single_rdata", 32'(rd_data), 32'h12ED48);
    chk("single_hold", 32'(rom_addr), 32'h12);

    // Move the pointer back to 0, then check round-robin fairness
    step(4'b1000, 4'b0000);
    chk("pre_fair_gnt", 32'(gnt), 32'h8);
    for (int i = 0; i < 5; i++) begin
      step(fair_req[i], 4'b0000);
      chk("fair_gnt", 32'(gnt), 32'(fair_gnt[i]));
    end

    // Wrap: ptr=3 with req=0011 goes to 0, and ptr then points at 1
    step(4'b0100, 4'b0000);
    chk("wrap_setup", 32'(gnt), 32'h4);
    step(4'b0011, 4'b0000);
    chk("wrap_gnt", 32'(gnt), 32'h1);
    step(4'b0011, 4'b0000);
    chk("wrap_ptr1", 32'(gnt), 32'h2);

    // Lock burst by requester 1 while requester 2 waits
    step(4'b0001, 4'b0000);
    chk("lock_setup", 32'(gnt), 32'h1);
    for (int b = 0; b < 4; b++) begin
      addr_q[1] = 8'(8'h40 + b);
      addr_q[2] = 8'(8'h77 + b);
      step(4'b0110, (b < 3) ? 4'b0010 : 4'b0000);
      chk("lock_gnt", 32'(gnt), 32'h2);
      chk("lock_addr", 32'(rom_addr), 32'(8'h40 + b));
      if (b > 0) chk("lock_rdv", 32'(rd_valid), 32'h2);
    end
    step(4'b0100, 4'b0000);
    chk("lock_release_gnt", 32'(gnt), 32'h4);
    chk("lock_release_rdv", 32'(rd_valid), 32'h2);
    chk("lock_release_rdata", 32'(rd_data), 32'h43BC19);
    chk("lock_release_addr", 32'(rom_addr), 32'h7A);

    // The owner drops req while locked, so arbitration resumes in the same cycle
    addr_q[0] = 8'h21;
    step(4'b0001, 4'b0001);
    chk("drop_lockgnt", 32'(gnt), 32'h1);
    step(4'b1000, 4'b0000);
    chk("drop_rearb", 32'(gnt), 32'h8);

    // lock without req is ignored
    step(4'b0010, 4'b1101);
    chk("lock_noreq_gnt", 32'(gnt), 32'h2);
    step(4'b1001, 4'b0000);
    chk("lock_noreq_next", 32'(gnt), 32'h8);

    // Reset in the cycle after a locked grant to requester 2
    addr_q[0] = 8'h12;
    addr_q[2] = 8'h55;
    step(4'b0100, 4'b0100);
    chk("rstmid_gnt", 32'(gnt), 32'h4);
    @(posedge clk);
    #1;
    chk("rstmid_rdv_before", 32'(rd_valid), 32'h4);
    rst = 1'b1;
    req = 4'b1111;
    lock = 4'b0000;
    req_addr = {addr_q[3], addr_q[2], addr_q[1], addr_q[0]};
    #1;
    chk("rstmid_rdv_async", 32'(rd_valid), 32'h0);
    chk("rstmid_gnt_forced", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("rstmid_addr", 32'(rom_addr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_gnt", 32'(gnt), 32'h1);
    chk("rstmid_after_addr", 32'(rom_addr), 32'h12);

    // Idle for 10 cycles. A non-granted address change must not leak through.
    addr_q[0] = 8'h99;
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 4'b0000);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_addr", 32'(rom_addr), 32'h12);
      if (i > 0) chk("idle_rdv", 32'(rd_valid), 32'h0);
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
